// File: rtl/tone_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tone_seq_pkg : shared types for the tone sequencer (states, table entry)
// Rev 1.0
// ----------------------------------------------------------------------------
package tone_seq_pkg;

  localparam int SCALE_W   = 6;
  localparam int DUR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } state_e;

  typedef struct packed {
    logic [SCALE_W-1:0]   scale;
    logic [DUR_W_DEF-1:0] dur;
  } entry_t;

  function automatic logic is_rest(input logic [SCALE_W-1:0] scale);
    return (scale == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tone_seq_if : host control/config bus and generator outputs of tone_sequencer
// Rev 1.0 ; loop_mode exists only when TONE_SEQ_LOOP_EN is defined
// ----------------------------------------------------------------------------
interface tone_seq_if
  import tone_seq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int DUR_W     = DUR_W_DEF
);
  localparam int IDX_W = $clog2(NUM_STEPS);

  logic               start;
  logic               stop;
`ifdef TONE_SEQ_LOOP_EN
  logic               loop_mode;
`endif
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [SCALE_W-1:0] cfg_scale;
  logic [DUR_W-1:0]   cfg_dur;
  logic [SCALE_W-1:0] scale_out;
  logic               tone_en;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   step_idx;

  modport master (
    output start, stop,
`ifdef TONE_SEQ_LOOP_EN
    output loop_mode,
`endif
    output cfg_we, cfg_addr, cfg_scale, cfg_dur,
    input  scale_out, tone_en, busy, done, step_idx
  );

  modport slave (
    input  start, stop,
`ifdef TONE_SEQ_LOOP_EN
    input  loop_mode,
`endif
    input  cfg_we, cfg_addr, cfg_scale, cfg_dur,
    output scale_out, tone_en, busy, done, step_idx
  );

endinterface
`default_nettype wire

// File: rtl/tone_seq_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tone_seq_timer : TICK_DIV prescaler plus remaining-tick down-counter
// Rev 1.0
// ----------------------------------------------------------------------------
module tone_seq_timer #(
  parameter int TICK_DIV = 4096,
  parameter int DUR_W    = 8
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic [DUR_W-1:0] dur,
  output logic             expire
);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick;
  logic [DUR_W-1:0]  r_remaining;
  logic              w_wrap;

  assign w_wrap = run && (r_tick == c_tick_last);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick      <= '0;
      r_remaining <= '0;
    end else if (load) begin
      r_tick      <= '0;
      r_remaining <= dur;
    end else if (run) begin
      if (w_wrap) begin
        r_tick      <= '0;
        r_remaining <= r_remaining - DUR_W'(1);
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

  // Fires on the last cycle of the final tick, so a step lasts dur*TICK_DIV cycles.
  assign expire = w_wrap && (r_remaining == DUR_W'(1));

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tone_sequencer : plays a host-written (scale, duration) table on the tone generator
// Rev 1.0 ; TONE_SEQ_LOOP_EN adds loop_mode; DUR_W must equal tone_seq_pkg::DUR_W_DEF
// ----------------------------------------------------------------------------
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int TICK_DIV  = 4096,
  parameter int DUR_W     = DUR_W_DEF
) (
  input logic       sysclk,
  input logic       reset_n,
  tone_seq_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_STEPS - 1);

  entry_t             r_tbl [NUM_STEPS];
  entry_t             w_entry;
  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [SCALE_W-1:0] r_cur_scale;
  logic [SCALE_W-1:0] r_scale_out;
  logic [SCALE_W-1:0] w_scale_nxt;
  logic               r_tone_en;
  logic               w_tone_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_loop;
  logic               w_load;
  logic               w_run;
  logic               w_expire;
  logic               w_is_last;
  logic               w_end_mark;

`ifdef TONE_SEQ_LOOP_EN
  assign w_loop = bus.loop_mode;
`else
  assign w_loop = 1'b0;
`endif

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (bus.cfg_we) begin
      r_tbl[bus.cfg_addr] <= '{scale: bus.cfg_scale, dur: bus.cfg_dur};
    end
  end

  assign w_entry    = r_tbl[r_idx];
  assign w_is_last  = (r_idx == c_idx_last);
  assign w_end_mark = (w_entry.dur == '0);
  assign w_load     = (r_state == LOAD);
  assign w_run      = (r_state == PLAY);

  tone_seq_timer #(
    .TICK_DIV (TICK_DIV),
    .DUR_W    (DUR_W)
  ) u_timer (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .load    (w_load),
    .run     (w_run),
    .dur     (w_entry.dur),
    .expire  (w_expire)
  );

  // Snapshot of the playing entry, so table writes only take effect at the next LOAD.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_scale <= '0;
    end else if (w_load) begin
      r_cur_scale <= w_entry.scale;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
        end
      end
      LOAD: begin
        if (bus.stop) begin
          w_state_nxt = FINISH;
        end else if (w_end_mark) begin
          // A marker at step 0 always finishes, so an empty table cannot loop.
          if (w_loop && (r_idx != '0)) begin
            w_state_nxt = LOAD;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = FINISH;
          end
        end else begin
          w_state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          w_state_nxt = FINISH;
        end else if (w_expire) begin
          if (!w_is_last) begin
            w_state_nxt = LOAD;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end else if (w_loop) begin
            w_state_nxt = LOAD;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_scale_nxt = r_scale_out;
    w_tone_nxt  = r_tone_en;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_scale_nxt = '0;
        w_tone_nxt  = 1'b0;
      end
      LOAD: begin
        w_busy_nxt = 1'b1;
      end
      PLAY: begin
        w_scale_nxt = r_cur_scale;
        w_tone_nxt  = !is_rest(r_cur_scale);
        w_busy_nxt  = 1'b1;
      end
      FINISH: begin
        w_scale_nxt = '0;
        w_tone_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_scale_nxt = '0;
        w_tone_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_scale_out <= '0;
      r_tone_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_scale_out <= w_scale_nxt;
      r_tone_en   <= w_tone_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.scale_out = r_scale_out;
  assign bus.tone_en   = r_tone_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.step_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tone_sequencer : directed vector table plus hand sequences for tone_sequencer
// Rev 1.0 ; loop sequence included when TONE_SEQ_LOOP_EN is defined
// ----------------------------------------------------------------------------
module tb_tone_sequencer;
  import tone_seq_pkg::*;

  localparam int NUM_STEPS = 8;
  localparam int TICK_DIV  = 4;
  localparam int DUR_W     = 8;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;

  always #5 sysclk = ~sysclk;

  tone_seq_if #(.NUM_STEPS(NUM_STEPS), .DUR_W(DUR_W)) bus ();

  tone_sequencer #(
    .NUM_STEPS (NUM_STEPS),
    .TICK_DIV  (TICK_DIV),
    .DUR_W     (DUR_W)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int   n;
    logic start, stop, we;
    int   addr, ws, wd;
    int   e_scale;
    logic e_tone, e_busy, e_done;
    int   e_idx;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input int n, input logic st, input logic sp, input logic we,
                              input int a, input int ws, input int wd, input int es,
                              input logic et, input logic eb, input logic ed, input int ei);
    vec_t v;
    v.n = n; v.start = st; v.stop = sp; v.we = we; v.addr = a; v.ws = ws; v.wd = wd;
    v.e_scale = es; v.e_tone = et; v.e_busy = eb; v.e_done = ed; v.e_idx = ei;
    vecs.push_back(v);
  endfunction

  function automatic void add_w(input int a, input int ws, input int wd);
    add(1, 1'b0, 1'b0, 1'b1, a, ws, wd, 0, 1'b0, 1'b0, 1'b0, -1);
  endfunction

  function automatic void add_c(input int n, input logic st, input logic sp, input int es,
                                input logic et, input logic eb, input logic ed, input int ei);
    add(n, st, sp, 1'b0, 0, 0, 0, es, et, eb, ed, ei);
  endfunction

  task automatic check_out(input string name, input int es, input logic et,
                           input logic eb, input logic ed);
    n_tests++;
    if (bus.scale_out !== 6'(es) || bus.tone_en !== et || bus.busy !== eb || bus.done !== ed) begin
      n_fail++;
      $display("FAIL %s: got scale=%0d tone_en=%b busy=%b done=%b, expected scale=%0d tone_en=%b busy=%b done=%b",
               name, bus.scale_out, bus.tone_en, bus.busy, bus.done, es, et, eb, ed);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_entry(input int a, input int ws, input int wd);
    @(negedge sysclk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_scale = 6'(ws); bus.cfg_dur = 8'(wd);
    @(negedge sysclk);
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0; bus.cfg_scale = '0; bus.cfg_dur = '0;
`ifdef TONE_SEQ_LOOP_EN
    bus.loop_mode = 1'b0;
`endif

    // Melody with a rest step and an end marker at entry 3
    add_w(0, 10, 2); add_w(1, 0, 1); add_w(2, 20, 3);
    add_c(1, 1, 0, 0, 0, 0, 0, -1);
    add_c(1, 0, 0, 0, 0, 1, 0, 0);
    add_c(9, 0, 0, 10, 1, 1, 0, -1);
    add_c(5, 0, 0, 0, 0, 1, 0, -1);
    add_c(13, 0, 0, 20, 1, 1, 0, -1);
    add_c(1, 0, 0, 0, 0, 0, 1, 3);
    add_c(2, 0, 0, 0, 0, 0, 0, 3);
    // Full table of one-tick steps
    for (int a = 0; a < NUM_STEPS; a++) add_w(a, 5, 1);
    add_c(1, 1, 0, 0, 0, 0, 0, -1);
    add_c(1, 0, 0, 0, 0, 1, 0, 0);
    add_c(39, 0, 0, 5, 1, 1, 0, -1);
    add_c(1, 0, 0, 0, 0, 0, 1, 7);
    add_c(1, 0, 0, 0, 0, 0, 0, 7);
    // Stop three cycles into step 0, then start+stop together in IDLE
    add_w(0, 10, 2);
    add_c(1, 1, 0, 0, 0, 0, 0, -1);
    add_c(1, 0, 0, 0, 0, 1, 0, 0);
    add_c(2, 0, 0, 10, 1, 1, 0, 0);
    add_c(1, 0, 1, 10, 1, 1, 0, 0);
    add_c(1, 0, 0, 0, 0, 0, 1, 0);
    add_c(1, 0, 0, 0, 0, 0, 0, 0);
    add_c(1, 1, 1, 0, 0, 0, 0, 0);
    add_c(3, 0, 0, 0, 0, 0, 0, 0);
    // Start while busy is ignored; rewriting the playing entry waits for the next run
    add_w(1, 0, 0);
    add_c(1, 1, 0, 0, 0, 0, 0, -1);
    add_c(1, 0, 0, 0, 0, 1, 0, 0);
    add_c(1, 0, 0, 10, 1, 1, 0, 0);
    add_c(1, 1, 0, 10, 1, 1, 0, 0);
    add(1, 1'b0, 1'b0, 1'b1, 0, 30, 2, 10, 1'b1, 1'b1, 1'b0, 0);
    add_c(6, 0, 0, 10, 1, 1, 0, -1);
    add_c(1, 0, 0, 0, 0, 0, 1, 1);
    add_c(1, 0, 0, 0, 0, 0, 0, 1);
    add_c(1, 1, 0, 0, 0, 0, 0, -1);
    add_c(1, 0, 0, 0, 0, 1, 0, 0);
    add_c(9, 0, 0, 30, 1, 1, 0, -1);
    add_c(1, 0, 0, 0, 0, 0, 1, 1);
    add_c(1, 0, 0, 0, 0, 0, 0, 1);

    repeat (3) @(posedge sysclk);
    #1;
    check_out("reset_outputs", 0, 1'b0, 1'b0, 1'b0);
    check_val("reset_step_idx", int'(bus.step_idx), 0);
    @(negedge sysclk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].n; c++) begin
        @(negedge sysclk);
        bus.start = vecs[k].start; bus.stop = vecs[k].stop; bus.cfg_we = vecs[k].we;
        bus.cfg_addr = 3'(vecs[k].addr); bus.cfg_scale = 6'(vecs[k].ws); bus.cfg_dur = 8'(vecs[k].wd);
        @(posedge sysclk);
        #1;
        check_out($sformatf("vec%0d.%0d", k, c), vecs[k].e_scale, vecs[k].e_tone,
                  vecs[k].e_busy, vecs[k].e_done);
        if (vecs[k].e_idx >= 0)
          check_val($sformatf("vec%0d.%0d_step_idx", k, c), int'(bus.step_idx), vecs[k].e_idx);
      end
    end
    @(negedge sysclk);
    bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0;

    // Asynchronous reset in the middle of a playing step
    @(negedge sysclk); bus.start = 1'b1;
    @(negedge sysclk); bus.start = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;
    check_val("pre_reset_tone_en", int'(bus.tone_en), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_out("async_reset_silence", 0, 1'b0, 1'b0, 1'b0);
    check_val("async_reset_step_idx", int'(bus.step_idx), 0);
    @(negedge sysclk); reset_n = 1'b1;
    @(negedge sysclk); bus.start = 1'b1;
    @(posedge sysclk); #1;
    check_out("empty_table_after_start", 0, 1'b0, 1'b0, 1'b0);
    @(negedge sysclk); bus.start = 1'b0;
    @(posedge sysclk); #1;
    check_out("empty_table_load", 0, 1'b0, 1'b1, 1'b0);
    @(posedge sysclk); #1;
    check_out("empty_table_done", 0, 1'b0, 1'b0, 1'b1);

`ifdef TONE_SEQ_LOOP_EN
    begin
      int bad;
      int got;
      bad = 0;
      got = 0;
      write_entry(0, 7, 1);
      bus.loop_mode = 1'b1;
      bus.start = 1'b1;
      @(negedge sysclk); bus.start = 1'b0;
      repeat (2) @(posedge sysclk);
      #1;
      for (int i = 0; i < 30; i++) begin
        if (!(bus.tone_en === 1'b1 && bus.scale_out === 6'd7 && bus.busy === 1'b1 && bus.done === 1'b0))
          bad++;
        @(posedge sysclk);
        #1;
      end
      check_val("loop_hold_bad_cycles", bad, 0);
      @(negedge sysclk); bus.stop = 1'b1;
      for (int i = 0; i < 6 && got == 0; i++) begin
        @(posedge sysclk);
        #1;
        bus.stop = 1'b0;
        if (bus.done === 1'b1) got = 1;
      end
      check_val("loop_stop_done", got, 1);
      bus.loop_mode = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
